// File: rtl/key_conditioner.sv
// key_conditioner
//   Conditions raw board push-buttons for the game CPU. Each key is
//   synchronised, debounced, turned into one-cycle press/release pulses and
//   optionally given auto-repeat pulses while it is held.
//
// Ports
//   clk          system clock (single domain)
//   rst_n        asynchronous active-low reset
//   keys_in      raw asynchronous button pins                [NKEYS]
//   keys_db      debounced level, 1 = pressed                 [NKEYS]
//   key_press    one-cycle pulse on debounced 0->1            [NKEYS]
//   key_release  one-cycle pulse on debounced 1->0            [NKEYS]
//   key_rep      one-cycle auto-repeat pulse while held       [NKEYS]
//
// Parameters
//   DB_CYCLES    consecutive stable cycles needed to accept a new level (>=1)
//   REP_DELAY    cycles from key_press to first key_rep; 0 disables repeat
//   REP_PERIOD   cycles between later key_rep pulses (>=1)
//   INVERT       1 = pins are active-low
module key_conditioner #(
  parameter int NKEYS      = 4,
  parameter int DB_CYCLES  = 50000,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_PERIOD = 5000000,
  parameter int INVERT     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NKEYS-1:0] keys_in,
  output logic [NKEYS-1:0] keys_db,
  output logic [NKEYS-1:0] key_press,
  output logic [NKEYS-1:0] key_release,
  output logic [NKEYS-1:0] key_rep
);

  localparam int DBW     = $clog2(DB_CYCLES + 1);
  localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int RW      = $clog2(REP_MAX + 1);

  localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
  localparam logic [RW-1:0]  DLY_LAST = (REP_DELAY > 0) ? RW'(REP_DELAY - 1) : '0;
  localparam logic [RW-1:0]  PER_LAST = RW'(REP_PERIOD - 1);
  localparam bit             REP_EN   = (REP_DELAY > 0);

  typedef enum logic {
    IDLE,
    HELD
  } rep_state_t;

  // ------------------------------------------------------------------
  // Synchroniser
  // ------------------------------------------------------------------
  logic [NKEYS-1:0] s;
  logic [NKEYS-1:0] sync1;
  logic [NKEYS-1:0] sync2;

  assign s = (INVERT != 0) ? ~keys_in : keys_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= s;
      sync2 <= sync1;
    end
  end

  // ------------------------------------------------------------------
  // Debounce and edge pulses
  // ------------------------------------------------------------------
  logic [DBW-1:0]   db_cnt     [NKEYS];
  logic [DBW-1:0]   db_cnt_nxt [NKEYS];
  logic [NKEYS-1:0] db_nxt;
  logic [NKEYS-1:0] press_nxt;
  logic [NKEYS-1:0] rel_nxt;

  // A mismatch must persist for DB_CYCLES consecutive cycles; any return to
  // the accepted level clears the count, so short glitches never propagate.
  always_comb begin
    db_nxt    = keys_db;
    press_nxt = '0;
    rel_nxt   = '0;
    for (int unsigned i = 0; i < NKEYS; i++) begin
      db_cnt_nxt[i] = '0;
      if (sync2[i] != keys_db[i]) begin
        if (db_cnt[i] == DB_LAST) begin
          db_nxt[i]    = sync2[i];
          press_nxt[i] = sync2[i];
          rel_nxt[i]   = ~sync2[i];
        end else begin
          db_cnt_nxt[i] = db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys_db     <= '0;
      key_press   <= '0;
      key_release <= '0;
      for (int unsigned i = 0; i < NKEYS; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      keys_db     <= db_nxt;
      key_press   <= press_nxt;
      key_release <= rel_nxt;
      for (int unsigned i = 0; i < NKEYS; i++) begin
        db_cnt[i] <= db_cnt_nxt[i];
      end
    end
  end

  // ------------------------------------------------------------------
  // Auto-repeat
  // ------------------------------------------------------------------
  rep_state_t       st      [NKEYS];
  rep_state_t       st_nxt  [NKEYS];
  logic [RW-1:0]    rc      [NKEYS];
  logic [RW-1:0]    rc_nxt  [NKEYS];
  logic [NKEYS-1:0] phase;
  logic [NKEYS-1:0] phase_nxt;
  logic [NKEYS-1:0] rep_nxt;

  // The FSM reacts to the same-cycle press/release decision rather than the
  // registered pulse, so rc is 0 in the key_press cycle and the first repeat
  // lands exactly REP_DELAY cycles later. phase selects delay vs period.
  always_comb begin
    phase_nxt = phase;
    rep_nxt   = '0;
    for (int unsigned i = 0; i < NKEYS; i++) begin
      st_nxt[i] = st[i];
      rc_nxt[i] = rc[i];
      case (st[i])
        IDLE: begin
          if (REP_EN && press_nxt[i]) begin
            st_nxt[i]    = HELD;
            rc_nxt[i]    = '0;
            phase_nxt[i] = 1'b0;
          end
        end
        HELD: begin
          if (rel_nxt[i]) begin
            st_nxt[i]    = IDLE;
            rc_nxt[i]    = '0;
            phase_nxt[i] = 1'b0;
          end else if ((!phase[i] && rc[i] == DLY_LAST) ||
                       ( phase[i] && rc[i] == PER_LAST)) begin
            rep_nxt[i]   = 1'b1;
            rc_nxt[i]    = '0;
            phase_nxt[i] = 1'b1;
          end else begin
            rc_nxt[i] = rc[i] + RW'(1);
          end
        end
        default: begin
          st_nxt[i]    = IDLE;
          rc_nxt[i]    = '0;
          phase_nxt[i] = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= '0;
      key_rep <= '0;
      for (int unsigned i = 0; i < NKEYS; i++) begin
        st[i] <= IDLE;
        rc[i] <= '0;
      end
    end else begin
      phase   <= phase_nxt;
      key_rep <= rep_nxt;
      for (int unsigned i = 0; i < NKEYS; i++) begin
        st[i] <= st_nxt[i];
        rc[i] <= rc_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

  localparam int NK   = 4;
  localparam int DB   = 4;
  localparam int RDLY = 10;
  localparam int RPER = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] keys_in;
  logic [NK-1:0] keys_db, key_press, key_release, key_rep;
  logic [NK-1:0] keys_in_i;
  logic [NK-1:0] keys_db_i, key_press_i, key_release_i, key_rep_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_conditioner #(
    .NKEYS(NK), .DB_CYCLES(DB), .REP_DELAY(RDLY), .REP_PERIOD(RPER), .INVERT(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .keys_in(keys_in), .keys_db(keys_db),
    .key_press(key_press), .key_release(key_release), .key_rep(key_rep)
  );

  key_conditioner #(
    .NKEYS(NK), .DB_CYCLES(DB), .REP_DELAY(RDLY), .REP_PERIOD(RPER), .INVERT(1)
  ) dut_i (
    .clk(clk), .rst_n(rst_n), .keys_in(keys_in_i), .keys_db(keys_db_i),
    .key_press(key_press_i), .key_release(key_release_i), .key_rep(key_rep_i)
  );

  // Reference model, instance 0 = non-inverted, 1 = inverted pins.
  logic [NK-1:0] m_d1 [2];
  logic [NK-1:0] m_d2 [2];
  logic [NK-1:0] m_db [2];
  logic [NK-1:0] m_pr [2];
  logic [NK-1:0] m_rl [2];
  logic [NK-1:0] m_rp [2];
  int            m_run   [2][NK];
  int            m_since [2][NK];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_d1[i] = '0; m_d2[i] = '0; m_db[i] = '0;
      m_pr[i] = '0; m_rl[i] = '0; m_rp[i] = '0;
      for (int k = 0; k < NK; k++) begin
        m_run[i][k] = 0;
        m_since[i][k] = 0;
      end
    end
  endtask

  // Level seen by the debouncer is the pin value from two clock edges ago.
  // A new level is accepted after DB consecutive differing observations.
  // Repeats fire at RDLY, RDLY+RPER, ... cycles after the press while held.
  task automatic model_step(input int i, input logic [NK-1:0] raw);
    logic [NK-1:0] lvl;
    logic [NK-1:0] seen;
    lvl  = (i == 1) ? ~raw : raw;
    seen = m_d2[i];
    m_d2[i] = m_d1[i];
    m_d1[i] = lvl;
    m_pr[i] = '0; m_rl[i] = '0; m_rp[i] = '0;
    for (int k = 0; k < NK; k++) begin
      if (seen[k] != m_db[i][k]) begin
        m_run[i][k]++;
        if (m_run[i][k] == DB) begin
          m_db[i][k] = seen[k];
          if (seen[k]) m_pr[i][k] = 1'b1;
          else         m_rl[i][k] = 1'b1;
          m_run[i][k] = 0;
        end
      end else begin
        m_run[i][k] = 0;
      end
      if (m_pr[i][k]) begin
        m_since[i][k] = 0;
      end else if (m_db[i][k]) begin
        m_since[i][k]++;
        if (RDLY > 0 && (m_since[i][k] == RDLY ||
            (m_since[i][k] > RDLY && (m_since[i][k] - RDLY) % RPER == 0)))
          m_rp[i][k] = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("keys_db",       keys_db,       m_db[0]);
    chk("key_press",     key_press,     m_pr[0]);
    chk("key_release",   key_release,   m_rl[0]);
    chk("key_rep",       key_rep,       m_rp[0]);
    chk("inv_keys_db",   keys_db_i,     m_db[1]);
    chk("inv_key_press", key_press_i,   m_pr[1]);
    chk("inv_key_rel",   key_release_i, m_rl[1]);
    chk("inv_key_rep",   key_rep_i,     m_rp[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      model_step(0, keys_in);
      model_step(1, keys_in_i);
    end
    #1;
    compare_all();
  endtask

  initial begin
    int lat, n_press, p_off, n_rep, first_rep, last_rep, rel_off, rep_after;
    logic [NK-1:0] seen;
    logic [NK-1:0] pr_seen;

    rst_n     = 1'b0;
    keys_in   = '0;
    keys_in_i = '1;
    model_reset();
    repeat (3) tick();
    chk("reset_db",  keys_db,  '0);
    chk("reset_rep", key_rep,  '0);
    #3 rst_n = 1'b1;
    repeat (4) tick();

    // 1. Clean press on key 0
    keys_in[0] = 1'b1;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (lat < 0 && key_press[0]) begin
        lat = n;
        chk("t1_press_only", key_press, 4'b0001);
      end
    end
    chk_int("t1_press_latency", lat, 6);
    keys_in[0] = 1'b0;
    repeat (10) tick();

    // 2. Glitch on key 1
    seen = '0;
    keys_in[1] = 1'b1;
    repeat (3) begin tick(); seen |= keys_db | key_press | key_release; end
    keys_in[1] = 1'b0;
    repeat (10) begin tick(); seen |= keys_db | key_press | key_release; end
    chk("t2_glitch_bit1", seen & 4'b0010, 4'b0000);

    // 3. Bounce on key 2: 1,0,1,1,0 then 1
    n_press = 0;
    p_off = -1;
    keys_in[2] = 1'b1; tick(); if (key_press[2]) n_press++;
    keys_in[2] = 1'b0; tick(); if (key_press[2]) n_press++;
    keys_in[2] = 1'b1; tick(); if (key_press[2]) n_press++;
    tick();            if (key_press[2]) n_press++;
    keys_in[2] = 1'b0; tick(); if (key_press[2]) n_press++;
    keys_in[2] = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      tick();
      if (key_press[2]) begin n_press++; p_off = n; end
    end
    chk_int("t3_press_count", n_press, 1);
    chk_int("t3_press_offset", p_off, 6);
    keys_in[2] = 1'b0;
    repeat (10) tick();

    // 4. Auto-repeat on key 0; raw fall 36 cycles after press so that
    //    keys_db falls 42 cycles after press, after the repeat at +40.
    keys_in[0] = 1'b1;
    lat = -1;
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      tick();
      if (key_press[0]) lat = n;
    end
    chk_int("t4_press_latency", lat, 6);
    n_rep = 0; first_rep = -1; last_rep = -1; rel_off = -1; rep_after = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (key_rep[0]) begin
        if (rel_off >= 0) rep_after++;
        n_rep++;
        if (first_rep < 0) first_rep = k;
        last_rep = k;
      end
      if (key_release[0] && rel_off < 0) rel_off = k - 36;
      if (k == 36) keys_in[0] = 1'b0;
    end
    chk_int("t4_rep_count", n_rep, 7);
    chk_int("t4_first_rep", first_rep, 10);
    chk_int("t4_last_rep", last_rep, 40);
    chk_int("t4_release_offset", rel_off, 6);
    chk_int("t4_rep_after_release", rep_after, 0);

    // 5. Asynchronous reset with key 0 held and key 3 mid-debounce
    keys_in[0] = 1'b1;
    repeat (10) tick();
    keys_in[3] = 1'b1;
    repeat (4) tick();
    chk("t5_pre_db", keys_db, 4'b0001);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t5_async_db",    keys_db,     '0);
    chk("t5_async_press", key_press,   '0);
    chk("t5_async_rel",   key_release, '0);
    chk("t5_async_rep",   key_rep,     '0);
    keys_in = 4'b1001;
    repeat (2) tick();
    #3 rst_n = 1'b1;
    lat = -1;
    pr_seen = '0;
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      tick();
      if (key_press != '0) begin lat = n; pr_seen = key_press; end
    end
    chk_int("t5_press_latency", lat, 6);
    chk("t5_press_vector", pr_seen, 4'b1001);
    keys_in = '0;
    repeat (10) tick();

    // 6. Inverted instance: idle high pins, then key 1 driven low
    chk("t6_idle_db", keys_db_i, '0);
    keys_in_i[1] = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      tick();
      if (key_press_i[1]) lat = n;
    end
    chk_int("t6_press_latency", lat, 6);
    keys_in_i[1] = 1'b1;
    repeat (10) tick();

    // Randomised traffic on both instances, slow then fast toggling
    for (int c = 0; c < 900; c++) begin
      for (int k = 0; k < NK; k++) begin
        if ($urandom_range(0, (c < 500) ? 17 : 4) == 0) keys_in[k]   = ~keys_in[k];
        if ($urandom_range(0, (c < 500) ? 15 : 5) == 0) keys_in_i[k] = ~keys_in_i[k];
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
